ls_pd_sequencer: RTL and testbench
==================================

# ls_pd_sequencer

Power-domain sequencer for a bank of 1.8 V to 3.3 V level shifters. It owns every shifter's PD pin and A input. It waits for the 3.3 V supply-good flag, arriving through a 3.3 V to 1.8 V shifter, then lets the supply settle and releases channels one at a time to limit inrush. After that it passes core data through. It sits in the 1.8 V digital core between the analog-front-end control registers and the shifter cells.

## Interface
Parameters:
- N_CH, 8, number of shifter channels (1..32)
- SETTLE_CYC, 16, cycles to wait after supply-good before the first channel release (≥1)
- STEP_CYC, 4, cycles between successive enabled-channel releases (≥1)
- TIMEOUT_CYC, 1024, maximum cycles spent waiting for supply-good before fault (≥1)

Ports:
- clk, in, 1, core clock
- rst_n, in, 1, reset: synchronous, active-low
- en, in, 1, power-up request; level-sensitive
- avdd_ok, in, 1, 3.3 V supply-good; asynchronous to clk
- ch_mask, in, N_CH, channels to power up; sampled on the OFF→WAIT_SUP transition
- data_in, in, N_CH, core data for the shifter A inputs
- ls_pd, out, N_CH, shifter PD pins; 1 = powered down
- ls_a, out, N_CH, shifter A inputs
- ready, out, 1, all enabled channels released and data passing
- busy, out, 1, sequencing in progress (WAIT_SUP, SETTLE, RELEASE, DRAIN)
- fault, out, 1, supply timeout or supply loss; sticky until en=0

## Operation
- avdd_ok passes through a 2-flop synchronizer; internal signal avdd_s.
- States: OFF, WAIT_SUP, SETTLE, RELEASE, ON, DRAIN, FAULT.
- OFF:
  - ls_pd all 1s, ls_a 0.
  - en=1 → WAIT_SUP; latch ch_mask into mask_q; load the timeout counter.
- WAIT_SUP:
  - avdd_s=1 → SETTLE; load the settle counter with SETTLE_CYC-1.
  - The timeout counter reaching 0 → FAULT.
- SETTLE:
  - Count down; at 0 → RELEASE with idx=0.
- RELEASE:
  - If mask_q[idx]=1: clear ls_pd[idx], then wait STEP_CYC cycles before advancing idx.
  - If mask_q[idx]=0: advance idx in 1 cycle.
  - After idx=N_CH-1 completes → ON.
  - mask_q all 0s → ON after N_CH cycles.
- ON:
  - ready=1.
  - ls_a = data_in & ~ls_pd, registered.
- Supply loss: avdd_s=0 in SETTLE, RELEASE or ON → FAULT.
- Power-down request: en=0 in WAIT_SUP, SETTLE, RELEASE or ON → DRAIN.
  - DRAIN forces ls_a to 0 with ls_pd unchanged for one cycle, then → OFF, where ls_pd goes all 1s.
  - A is therefore never high while PD falls or rises.
- FAULT:
  - fault=1, ls_pd all 1s, ls_a 0.
  - en=0 → OFF, which clears fault.
  - en=1 holds FAULT; there is no automatic retry.
- Priority when en=0 and supply loss occur in the same cycle: en=0 wins → DRAIN, no fault.
- Released channels stay released until DRAIN or FAULT. mask_q does not change outside OFF.

## Timing
- Reset values: state OFF, ls_pd all 1s, ls_a 0, ready 0, busy 0, fault 0, all counters 0.
- All outputs are registered.
- avdd_ok rising to SETTLE entry: 3 cycles (2 synchronizer + 1 FSM).
- From SETTLE entry, the first enabled channel at index k has ls_pd low SETTLE_CYC+k+1 cycles later.
- data_in to ls_a: 1 cycle in ON.
- en falling to ls_a=0: 1 cycle. en falling to ls_pd all 1s: 2 cycles.
- Supply loss to ls_pd all 1s: 2 cycles after avdd_ok falls plus 1, i.e. 3 cycles.
- Reset asserted mid-sequence forces reset values on the next edge, regardless of state.

## Structure
- Package ls_ctrl_pkg holds:
  - the state enum (3 bits);
  - the counter-width function clog2;
  - counter width CNT_W = clog2(max(SETTLE_CYC, STEP_CYC, TIMEOUT_CYC)) + 1.
- Sub-module sync_2ff: parameterized-width 2-flop synchronizer, used for avdd_ok.
- The FSM, the shared down-counter (reloaded per state) and the idx counter live in ls_pd_sequencer.

## Test plan
All scenarios use N_CH=4, SETTLE_CYC=16, STEP_CYC=4, TIMEOUT_CYC=64.
- Normal power-up:
  - Stimulus: ch_mask=4'b1011, en=1, avdd_ok=1.
  - Required: ls_pd steps 1111 → 1110 → 1100 → 0100, with 4 cycles between drops and channel 2 skipped in 1 cycle.
  - Required: ready rises after the last step; ls_a follows data_in&4'b1011 with 1-cycle latency.
- Supply timeout:
  - Stimulus: en=1, avdd_ok held 0.
  - Required: fault=1 on cycle 65 after WAIT_SUP entry; ls_pd stays 1111.
  - Stimulus: en=0. Required: fault clears next cycle.
- Supply loss in ON:
  - Stimulus: drop avdd_ok.
  - Required: ls_pd=1111 and ls_a=0 within 3 cycles; fault=1; ready=0.
- Graceful power-down mid-RELEASE:
  - Stimulus: en=0 with two channels released.
  - Required: ls_a=0 the next cycle; ls_pd=1111 one cycle later; fault stays 0.
- Simultaneous events:
  - Stimulus: en=0 and avdd_ok loss on the same synchronized cycle.
  - Required: DRAIN path taken; fault=0.
- Reset mid-SETTLE:
  - Stimulus: rst_n=0 for 1 cycle.
  - Required: all outputs return to reset values.
  - Stimulus: en=1 with avdd_ok=1. Required: a full sequence restarts from WAIT_SUP.

Source files
------------

// File: rtl/ls_ctrl_pkg.sv
// Shared types and helpers for the level-shifter power-domain sequencer.
//   state_e   : sequencer FSM states (3-bit encoding)
//   clog2     : ceiling log2 for sizing counters and indices
//   cnt_width : shared down-counter width, clog2(max(settle, step, timeout)) + 1
package ls_ctrl_pkg;

  typedef enum logic [2:0] {
    StOff,
    StWaitSup,
    StSettle,
    StRelease,
    StOn,
    StDrain,
    StFault
  } state_e;

  function automatic int unsigned clog2(input int unsigned x);
    int unsigned r;
    int unsigned v;
    r = 0;
    v = 1;
    while (v < x) begin
      v = v << 1;
      r = r + 1;
    end
    return r;
  endfunction

  function automatic int unsigned cnt_width(input int unsigned settle_cyc,
                                            input int unsigned step_cyc,
                                            input int unsigned timeout_cyc);
    int unsigned m;
    m = settle_cyc;
    if (step_cyc > m) m = step_cyc;
    if (timeout_cyc > m) m = timeout_cyc;
    return clog2(m) + 1;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for slow level signals crossing into the clk domain.
//   clk   : destination clock
//   rst_n : synchronous active-low reset, clears both stages
//   d     : asynchronous input
//   q     : synchronized output, two clk cycles after d
module sync_2ff #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/ls_pd_sequencer.sv
// Power-domain sequencer for a bank of 1.8 V -> 3.3 V level shifters.
// Waits for the synchronized 3.3 V supply-good, lets it settle, then releases the
// masked channels' PD pins one at a time before passing core data to the A inputs.
//   clk, rst_n : core clock, synchronous active-low reset
//   en         : power-up request (level)
//   avdd_ok    : 3.3 V supply-good, asynchronous
//   ch_mask    : channels to power up, latched when leaving OFF
//   data_in    : core data for shifter A inputs
//   ls_pd      : shifter PD pins (1 = powered down)
//   ls_a       : shifter A inputs
//   ready      : sequencing complete, data passing
//   busy       : sequencing or draining in progress
//   fault      : supply timeout or loss; held until en drops
module ls_pd_sequencer
  import ls_ctrl_pkg::*;
#(
  parameter int unsigned N_CH        = 8,
  parameter int unsigned SETTLE_CYC  = 16,
  parameter int unsigned STEP_CYC    = 4,
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  input  logic            avdd_ok,
  input  logic [N_CH-1:0] ch_mask,
  input  logic [N_CH-1:0] data_in,
  output logic [N_CH-1:0] ls_pd,
  output logic [N_CH-1:0] ls_a,
  output logic            ready,
  output logic            busy,
  output logic            fault
);

  localparam int unsigned CNT_W = cnt_width(SETTLE_CYC, STEP_CYC, TIMEOUT_CYC);
  localparam int unsigned IDX_W = (clog2(N_CH) > 0) ? clog2(N_CH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_CH - 1);

  logic avdd_s;

  sync_2ff #(
    .WIDTH (1)
  ) u_avdd_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (avdd_ok),
    .q     (avdd_s)
  );

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [N_CH-1:0]  mask_q, mask_d;
  logic [N_CH-1:0]  ls_pd_d, ls_a_d;
  logic             ready_d, busy_d, fault_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StOff;
      cnt_q   <= '0;
      idx_q   <= '0;
      mask_q  <= '0;
      ls_pd   <= '1;
      ls_a    <= '0;
      ready   <= 1'b0;
      busy    <= 1'b0;
      fault   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      mask_q  <= mask_d;
      ls_pd   <= ls_pd_d;
      ls_a    <= ls_a_d;
      ready   <= ready_d;
      busy    <= busy_d;
      fault   <= fault_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    mask_d  = mask_q;
    ls_pd_d = ls_pd;

    unique case (state_q)
      StOff: begin
        if (en) begin
          state_d = StWaitSup;
          mask_d  = ch_mask;
          cnt_d   = CNT_W'(TIMEOUT_CYC);
        end
      end
      StWaitSup: begin
        if (!en) begin
          state_d = StDrain;
        end else if (avdd_s) begin
          state_d = StSettle;
          cnt_d   = CNT_W'(SETTLE_CYC - 1);
        end else if (cnt_q == '0) begin
          state_d = StFault;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      StSettle: begin
        // en=0 outranks supply loss so a requested shutdown never reports a fault
        if (!en) begin
          state_d = StDrain;
        end else if (!avdd_s) begin
          state_d = StFault;
        end else if (cnt_q == '0) begin
          state_d = StRelease;
          idx_d   = '0;
          cnt_d   = CNT_W'(STEP_CYC - 1);
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      StRelease: begin
        if (!en) begin
          state_d = StDrain;
        end else if (!avdd_s) begin
          state_d = StFault;
        end else begin
          // The release cycle itself counts as the first of the STEP_CYC cycles
          if (mask_q[idx_q]) ls_pd_d[idx_q] = 1'b0;
          if (!mask_q[idx_q] || cnt_q == '0) begin
            cnt_d = CNT_W'(STEP_CYC - 1);
            if (idx_q == LAST_IDX) state_d = StOn;
            else                   idx_d   = idx_q + IDX_W'(1);
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
      end
      StOn: begin
        if (!en)          state_d = StDrain;
        else if (!avdd_s) state_d = StFault;
      end
      StDrain: begin
        state_d = StOff;
      end
      StFault: begin
        if (!en) state_d = StOff;
      end
      default: begin
        state_d = StOff;
      end
    endcase

    if (state_d == StOff || state_d == StFault) ls_pd_d = '1;

    // Outputs are decoded from the next state so they register with the transition
    ls_a_d  = (state_d == StOn) ? (data_in & ~ls_pd_d) : '0;
    ready_d = (state_d == StOn);
    fault_d = (state_d == StFault);
    busy_d  = (state_d == StWaitSup) || (state_d == StSettle) ||
              (state_d == StRelease) || (state_d == StDrain);
  end

endmodule

// File: tb/tb_ls_pd_sequencer.sv
module tb_ls_pd_sequencer;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       avdd_ok;
  logic [3:0] ch_mask;
  logic [3:0] data_in;
  logic [3:0] ls_pd;
  logic [3:0] ls_a;
  logic       ready;
  logic       busy;
  logic       fault;

  int errors;
  int checks;

  ls_pd_sequencer #(
    .N_CH        (4),
    .SETTLE_CYC  (16),
    .STEP_CYC    (4),
    .TIMEOUT_CYC (64)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
    .avdd_ok (avdd_ok),
    .ch_mask (ch_mask),
    .data_in (data_in),
    .ls_pd   (ls_pd),
    .ls_a    (ls_a),
    .ready   (ready),
    .busy    (busy),
    .fault   (fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b0; avdd_ok = 1'b0; ch_mask = '0; data_in = '0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
    checks++; if (ls_pd !== 4'b1111) begin errors++; $display("FAIL reset_ls_pd got=%b exp=1111", ls_pd); end
    checks++; if (ls_a !== 4'b0000) begin errors++; $display("FAIL reset_ls_a got=%b exp=0000", ls_a); end
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL reset_ready got=%b exp=0", ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (fault !== 1'b0) begin errors++; $display("FAIL reset_fault got=%b exp=0", fault); end
  endtask

  // Supply-good rises with en: SETTLE entered at c=2, drops at c=19, 23, 28, ON at c=31
  task automatic test_normal();
    logic [3:0] exp_pd;
    ch_mask = 4'b1011; en = 1'b1; avdd_ok = 1'b1; data_in = '0;
    tick();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL normal_busy got=%b exp=1", busy); end
    for (int c = 1; c <= 31; c++) begin
      tick();
      if (c >= 28)      exp_pd = 4'b0100;
      else if (c >= 23) exp_pd = 4'b1100;
      else if (c >= 19) exp_pd = 4'b1110;
      else              exp_pd = 4'b1111;
      checks++;
      if (ls_pd !== exp_pd) begin
        errors++; $display("FAIL normal_ls_pd c=%0d got=%b exp=%b", c, ls_pd, exp_pd);
      end
      if (c == 30 || c == 31) begin
        checks++;
        if (ready !== (c == 31)) begin
          errors++; $display("FAIL normal_ready c=%0d got=%b exp=%b", c, ready, c == 31);
        end
      end
    end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL normal_busy_on got=%b exp=0", busy); end
    data_in = 4'b1111;
    checks++; if (ls_a !== 4'b0000) begin errors++; $display("FAIL normal_ls_a_pre got=%b exp=0000", ls_a); end
    tick();
    checks++; if (ls_a !== 4'b1011) begin errors++; $display("FAIL normal_ls_a1 got=%b exp=1011", ls_a); end
    data_in = 4'b0110;
    tick();
    checks++; if (ls_a !== 4'b0010) begin errors++; $display("FAIL normal_ls_a2 got=%b exp=0010", ls_a); end
  endtask

  task automatic test_supply_loss();
    avdd_ok = 1'b0;
    tick(); tick();
    checks++; if (ls_pd !== 4'b0100) begin errors++; $display("FAIL loss_pd_early got=%b exp=0100", ls_pd); end
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL loss_ready_early got=%b exp=1", ready); end
    tick();
    checks++; if (ls_pd !== 4'b1111) begin errors++; $display("FAIL loss_ls_pd got=%b exp=1111", ls_pd); end
    checks++; if (ls_a !== 4'b0000) begin errors++; $display("FAIL loss_ls_a got=%b exp=0000", ls_a); end
    checks++; if (fault !== 1'b1) begin errors++; $display("FAIL loss_fault got=%b exp=1", fault); end
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL loss_ready got=%b exp=0", ready); end
    tick();
    checks++; if (fault !== 1'b1) begin errors++; $display("FAIL loss_fault_sticky got=%b exp=1", fault); end
    en = 1'b0;
    tick();
    checks++; if (fault !== 1'b0) begin errors++; $display("FAIL loss_fault_clear got=%b exp=0", fault); end
  endtask

  // WAIT_SUP entered at c=0; timeout counter expires into FAULT at c=65
  task automatic test_timeout();
    ch_mask = 4'b1111; en = 1'b1;
    tick();
    for (int c = 1; c <= 65; c++) begin
      tick();
      if (c >= 63) begin
        checks++;
        if (fault !== (c == 65)) begin
          errors++; $display("FAIL timeout_fault c=%0d got=%b exp=%b", c, fault, c == 65);
        end
      end
      checks++;
      if (ls_pd !== 4'b1111) begin
        errors++; $display("FAIL timeout_ls_pd c=%0d got=%b exp=1111", c, ls_pd);
      end
    end
    en = 1'b0;
    tick();
    checks++; if (fault !== 1'b0) begin errors++; $display("FAIL timeout_clear got=%b exp=0", fault); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL timeout_busy got=%b exp=0", busy); end
  endtask

  // Supply already good: SETTLE at c=1, ch0 drops c=18, ch1 c=22
  task automatic test_drain_mid_release();
    avdd_ok = 1'b1;
    tick(); tick();
    ch_mask = 4'b1011; en = 1'b1; data_in = 4'b1111;
    tick();
    for (int c = 1; c <= 22; c++) begin
      tick();
      if (c == 17) begin
        checks++; if (ls_pd !== 4'b1111) begin errors++; $display("FAIL drain_pd17 got=%b exp=1111", ls_pd); end
      end
      if (c == 18) begin
        checks++; if (ls_pd !== 4'b1110) begin errors++; $display("FAIL drain_pd18 got=%b exp=1110", ls_pd); end
      end
    end
    checks++; if (ls_pd !== 4'b1100) begin errors++; $display("FAIL drain_two_released got=%b exp=1100", ls_pd); end
    en = 1'b0;
    tick();
    checks++; if (ls_a !== 4'b0000) begin errors++; $display("FAIL drain_ls_a got=%b exp=0000", ls_a); end
    checks++; if (ls_pd !== 4'b1100) begin errors++; $display("FAIL drain_pd_hold got=%b exp=1100", ls_pd); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL drain_busy got=%b exp=1", busy); end
    tick();
    checks++; if (ls_pd !== 4'b1111) begin errors++; $display("FAIL drain_pd_off got=%b exp=1111", ls_pd); end
    checks++; if (fault !== 1'b0) begin errors++; $display("FAIL drain_fault got=%b exp=0", fault); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL drain_busy_off got=%b exp=0", busy); end
  endtask

  task automatic test_simultaneous();
    int n;
    ch_mask = 4'b0001; en = 1'b1;
    n = 0;
    tick();
    while (ready !== 1'b1 && n < 60) begin
      tick();
      n++;
    end
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL simul_ready_timeout got=%b exp=1", ready); end
    checks++; if (ls_pd !== 4'b1110) begin errors++; $display("FAIL simul_pd_on got=%b exp=1110", ls_pd); end
    avdd_ok = 1'b0;
    tick(); tick();
    en = 1'b0;
    tick();
    checks++; if (fault !== 1'b0) begin errors++; $display("FAIL simul_fault got=%b exp=0", fault); end
    checks++; if (ls_pd !== 4'b1110) begin errors++; $display("FAIL simul_drain_pd got=%b exp=1110", ls_pd); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL simul_drain_busy got=%b exp=1", busy); end
    tick();
    checks++; if (ls_pd !== 4'b1111) begin errors++; $display("FAIL simul_off_pd got=%b exp=1111", ls_pd); end
    checks++; if (fault !== 1'b0) begin errors++; $display("FAIL simul_off_fault got=%b exp=0", fault); end
  endtask

  task automatic test_reset_mid_settle();
    logic [3:0] exp_pd;
    avdd_ok = 1'b1;
    tick(); tick(); tick();
    ch_mask = 4'b1111; en = 1'b1;
    for (int c = 0; c <= 5; c++) tick();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rst_settle_busy got=%b exp=1", busy); end
    rst_n = 1'b0;
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy got=%b exp=0", busy); end
    checks++; if (ls_pd !== 4'b1111) begin errors++; $display("FAIL rst_mid_pd got=%b exp=1111", ls_pd); end
    checks++; if (ls_a !== 4'b0000) begin errors++; $display("FAIL rst_mid_ls_a got=%b exp=0000", ls_a); end
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL rst_mid_ready got=%b exp=0", ready); end
    checks++; if (fault !== 1'b0) begin errors++; $display("FAIL rst_mid_fault got=%b exp=0", fault); end
    rst_n = 1'b1;
    tick();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rst_restart_busy got=%b exp=1", busy); end
    // Synchronizer was cleared, so SETTLE is entered at c=2 again
    for (int c = 1; c <= 34; c++) begin
      tick();
      if (c >= 31)      exp_pd = 4'b0000;
      else if (c >= 27) exp_pd = 4'b1000;
      else if (c >= 23) exp_pd = 4'b1100;
      else if (c >= 19) exp_pd = 4'b1110;
      else              exp_pd = 4'b1111;
      checks++;
      if (ls_pd !== exp_pd) begin
        errors++; $display("FAIL restart_ls_pd c=%0d got=%b exp=%b", c, ls_pd, exp_pd);
      end
      if (c == 33 || c == 34) begin
        checks++;
        if (ready !== (c == 34)) begin
          errors++; $display("FAIL restart_ready c=%0d got=%b exp=%b", c, ready, c == 34);
        end
      end
    end
    en = 1'b0;
    tick(); tick();
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_normal();
    test_supply_loss();
    test_timeout();
    test_drain_mid_release();
    test_simultaneous();
    test_reset_mid_settle();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
